// File: rtl/gcd_arbiter.sv
// Round-robin sequencer sharing one extended-Euclid gcd unit between two requesters.
// Define GCD_ARB_CONST_TIME_EN to pad every job to exactly MAX_CYCLES WAIT cycles.
module gcd_arbiter #(
  parameter int WIDTH      = 8,
  parameter int MAX_CYCLES = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_0,
  input  logic [2*WIDTH-1:0] a_0,
  input  logic [2*WIDTH-1:0] b_0,
  input  logic               req_1,
  input  logic [2*WIDTH-1:0] a_1,
  input  logic [2*WIDTH-1:0] b_1,
  output logic               gnt_0,
  output logic               gnt_1,
  output logic               done_0,
  output logic               done_1,
  output logic [2*WIDTH-1:0] res_gcd,
  output logic [2*WIDTH-1:0] res_s,
  output logic [2*WIDTH-1:0] res_t,
  output logic               res_err,
  output logic               busy,
  output logic               gu_start,
  output logic [2*WIDTH-1:0] gu_a,
  output logic [2*WIDTH-1:0] gu_b,
  input  logic [2*WIDTH-1:0] gu_gcd,
  input  logic [2*WIDTH-1:0] gu_s,
  input  logic [2*WIDTH-1:0] gu_t,
  input  logic               gu_finish
);
  localparam int W  = 2*WIDTH;
  localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES-1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  gcd_q, gcd_d, s_q, s_d, t_q, t_d;
  logic          err_q, err_d;
  logic          win;
`ifdef GCD_ARB_CONST_TIME_EN
  // First finish is parked here so res_* still only move on entering RESP.
  logic          got_q, got_d;
  logic [W-1:0]  cg_q, cg_d, cs_q, cs_d, ct_q, ct_d;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    gcd_d    = gcd_q;
    s_d      = s_q;
    t_d      = t_q;
    err_d    = err_q;
    win      = 1'b0;
    gnt_0    = 1'b0;
    gnt_1    = 1'b0;
    done_0   = 1'b0;
    done_1   = 1'b0;
    gu_start = 1'b0;
`ifdef GCD_ARB_CONST_TIME_EN
    got_d    = got_q;
    cg_d     = cg_q;
    cs_d     = cs_q;
    ct_d     = ct_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_0 || req_1) begin
          win     = (req_0 && req_1) ? rr_q : req_1;
          owner_d = win;
          a_d     = win ? a_1 : a_0;
          b_d     = win ? b_1 : b_0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        gnt_0    = ~owner_q;
        gnt_1    = owner_q;
        gu_start = 1'b1;
        cnt_d    = '0;
`ifdef GCD_ARB_CONST_TIME_EN
        got_d    = 1'b0;
`endif
        state_d  = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
`ifdef GCD_ARB_CONST_TIME_EN
        if (gu_finish && !got_q) begin
          got_d = 1'b1;
          cg_d  = gu_gcd;
          cs_d  = gu_s;
          ct_d  = gu_t;
        end
        if (cnt_q == LAST) begin
          state_d = RESP;
          if (got_q) begin
            gcd_d = cg_q; s_d = cs_q; t_d = ct_q; err_d = 1'b0;
          end else if (gu_finish) begin
            gcd_d = gu_gcd; s_d = gu_s; t_d = gu_t; err_d = 1'b0;
          end else begin
            gcd_d = '0; s_d = '0; t_d = '0; err_d = 1'b1;
          end
        end
`else
        if (gu_finish) begin
          gcd_d   = gu_gcd;
          s_d     = gu_s;
          t_d     = gu_t;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == LAST) begin
          gcd_d   = '0;
          s_d     = '0;
          t_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        done_0  = ~owner_q;
        done_1  = owner_q;
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      s_q     <= '0;
      t_q     <= '0;
      err_q   <= 1'b0;
`ifdef GCD_ARB_CONST_TIME_EN
      got_q   <= 1'b0;
      cg_q    <= '0;
      cs_q    <= '0;
      ct_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      s_q     <= s_d;
      t_q     <= t_d;
      err_q   <= err_d;
`ifdef GCD_ARB_CONST_TIME_EN
      got_q   <= got_d;
      cg_q    <= cg_d;
      cs_q    <= cs_d;
      ct_q    <= ct_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign gu_a    = a_q;
  assign gu_b    = b_q;
  assign res_gcd = gcd_q;
  assign res_s   = s_q;
  assign res_t   = t_q;
  assign res_err = err_q;
endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural gcd unit, job-level timing/result model, directed + random jobs.
module tb_gcd_arbiter;
  localparam int WIDTH = 8;
  localparam int W     = 2*WIDTH;
  localparam int MC    = 32;
`ifdef GCD_ARB_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, req_0, req_1, gu_finish;
  logic [W-1:0] a_0, b_0, a_1, b_1, gu_gcd, gu_s, gu_t;
  logic         gnt_0, gnt_1, done_0, done_1, res_err, busy, gu_start;
  logic [W-1:0] res_gcd, res_s, res_t, gu_a, gu_b;

  gcd_arbiter #(.WIDTH(WIDTH), .MAX_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .a_0(a_0), .b_0(b_0),
    .req_1(req_1), .a_1(a_1), .b_1(b_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .res_gcd(res_gcd), .res_s(res_s), .res_t(res_t), .res_err(res_err),
    .busy(busy), .gu_start(gu_start), .gu_a(gu_a), .gu_b(gu_b),
    .gu_gcd(gu_gcd), .gu_s(gu_s), .gu_t(gu_t), .gu_finish(gu_finish)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;
  int gnt_cnt  = 0, done_cnt = 0, start_cnt = 0;
  int fin_d    = 0, fin_d2 = 0;
  bit stale    = 1'b0;
  int cd = 0, cd2 = 0;
  int rr = 0;
  int last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic void egcd(input int a, input int b, output int g, output int s, output int t);
    int r0 = a, r1 = b, s0 = 1, s1 = 0, t0 = 0, t1 = 1, q, tmp;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q*r1; r0 = r1; r1 = tmp;
      tmp = s0 - q*s1; s0 = s1; s1 = tmp;
      tmp = t0 - q*t1; t0 = t1; t1 = tmp;
    end
    g = r0; s = s0; t = t0;
  endfunction

  // Behavioural gcd unit: finish fin_d cycles after start, optional stale/extra pulses with junk data.
  always @(negedge clk) begin
    int g, s, t;
    gu_finish = 1'b0;
    gu_gcd = 16'h5A5A; gu_s = 16'h5A5A; gu_t = 16'h5A5A;
    if (rst) begin
      cd = 0; cd2 = 0;
    end else if (gu_start) begin
      cd = fin_d; cd2 = fin_d2;
      if (stale) begin
        gu_finish = 1'b1; gu_gcd = 16'hDEAD; gu_s = 16'hBEEF; gu_t = 16'hCAFE;
      end
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          egcd(int'(gu_a), int'(gu_b), g, s, t);
          gu_finish = 1'b1; gu_gcd = 16'(g); gu_s = 16'(s); gu_t = 16'(t);
        end
      end
      if (cd2 > 0) begin
        cd2--;
        if (cd2 == 0) begin
          gu_finish = 1'b1; gu_gcd = 16'h1111; gu_s = 16'h2222; gu_t = 16'h3333;
        end
      end
    end
  end

  // Pulse bookkeeping and exclusivity on every pulse cycle.
  always @(negedge clk) begin
    if (gnt_0 || gnt_1) gnt_cnt++;
    if (done_0 || done_1) done_cnt++;
    if (gu_start) start_cnt++;
    if (gnt_0 || gnt_1 || done_0 || done_1) begin
      chk("pulse_excl", {29'd0, gnt_0 & gnt_1, done_0 & done_1, (gnt_0 | gnt_1) & (done_0 | done_1)}, 32'd0);
      chk("start_with_gnt", {31'd0, gu_start}, {31'd0, gnt_0 | gnt_1});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic grant(input int who, input logic [W-1:0] a, input logic [W-1:0] b, output int L);
    int n = 0;
    L = -1;
    while (n < 10) begin
      tick(); n++;
      if (gnt_0 || gnt_1) break;
    end
    if (!(gnt_0 || gnt_1)) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    L = cyc;
    chk("gnt_who", {31'd0, gnt_1}, who);
    chk("gu_a", {16'd0, gu_a}, {16'd0, a});
    chk("gu_b", {16'd0, gu_b}, {16'd0, b});
    if (who == 0) req_0 = 1'b0; else req_1 = 1'b0;
  endtask

  task automatic finish_job(input int who, input int L, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] pg, ps, pt;
    bit hold_ok = 1'b1, ok;
    int n = 0, g, s, t, exp_d;
    pg = res_gcd; ps = res_s; pt = res_t;
    while (1) begin
      tick(); n++;
      if (done_0 || done_1) break;
      if (res_gcd !== pg || res_s !== ps || res_t !== pt) hold_ok = 1'b0;
      if (gu_a !== a || gu_b !== b) hold_ok = 1'b0;
      if (n > MC + 10) break;
    end
    if (!(done_0 || done_1)) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    ok = (fin_d >= 1 && fin_d <= MC) || (CT && fin_d2 >= 1 && fin_d2 <= MC);
    exp_d = (CT || !ok) ? L + MC + 1 : L + fin_d + 1;
    if (ok) egcd(int'(a), int'(b), g, s, t);
    else begin g = 0; s = 0; t = 0; end
    chk("done_cyc", cyc, exp_d);
    chk("done_who", {31'd0, done_1}, who);
    chk("res_gcd", {16'd0, res_gcd}, {16'd0, 16'(g)});
    chk("res_s", {16'd0, res_s}, {16'd0, 16'(s)});
    chk("res_t", {16'd0, res_t}, {16'd0, 16'(t)});
    chk("res_err", {31'd0, res_err}, {31'd0, !ok});
    chk("res_hold", {31'd0, hold_ok}, 32'd1);
    last_done = cyc;
    rr = who ^ 1;
    tick();
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic job(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
    int L;
    if (who == 0) begin a_0 = a; b_0 = b; req_0 = 1'b1; end
    else begin a_1 = a; b_1 = b; req_1 = 1'b1; end
    grant(who, a, b, L);
    if (L >= 0) finish_job(who, L, a, b);
  endtask

  task automatic contend(input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1);
    int L, first, second;
    a_0 = x0; b_0 = y0; a_1 = x1; b_1 = y1;
    req_0 = 1'b1; req_1 = 1'b1;
    first = rr; second = rr ^ 1;
    grant(first, first ? x1 : x0, first ? y1 : y0, L);
    if (L < 0) return;
    finish_job(first, L, first ? x1 : x0, first ? y1 : y0);
    grant(second, second ? x1 : x0, second ? y1 : y0, L);
    if (L < 0) return;
    chk("regrant_after_done", {31'd0, L > last_done}, 32'd1);
    finish_job(second, L, second ? x1 : x0, second ? y1 : y0);
  endtask

  initial begin
    int g0, s0, st0, L, dc;
    rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
    a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {28'd0, gnt_0, gnt_1, done_0, done_1}, 32'd0);
    chk("rst_gu_start", {31'd0, gu_start}, 32'd0);
    chk("rst_gu_ab", {gu_a, gu_b}, 32'd0);
    chk("rst_res", {res_gcd, res_s | res_t}, 32'd0);
    chk("rst_err", {31'd0, res_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Contention straight after reset: requester 0 first.
    fin_d = 20; fin_d2 = 0; stale = 1'b0;
    contend(16'd240, 16'd46, 16'd35, 16'd15);
    chk("cont_res_gcd", {16'd0, res_gcd}, 32'd5);
    chk("cont_res_s", {16'd0, res_s}, 32'h0001);
    chk("cont_res_t", {16'd0, res_t}, 32'hFFFE);

    // Single job with pulse counting.
    g0 = gnt_cnt; s0 = start_cnt;
    job(0, 16'd240, 16'd46);
    chk("single_gnt_once", gnt_cnt - g0, 32'd1);
    chk("single_start_once", start_cnt - s0, 32'd1);
    chk("single_res_gcd", {16'd0, res_gcd}, 32'd2);
    chk("single_res_s", {16'd0, res_s}, 32'hFFF7);
    chk("single_res_t", {16'd0, res_t}, 32'h002F);

    // Contention again: requester 1 now first.
    fin_d = 6;
    contend(16'd240, 16'd46, 16'd35, 16'd15);

    // Timeout, then a normal job.
    fin_d = 0;
    job(0, 16'd1234, 16'd77);
    fin_d = 9;
    job(0, 16'd1000, 16'd75);

    // Stale finish during LAUNCH must be ignored.
    fin_d = 7; stale = 1'b1;
    job(1, 16'd35, 16'd15);
    stale = 1'b0;

    // Finish on the very last WAIT cycle, and a second pulse later in WAIT.
    fin_d = MC;
    job(1, 16'd999, 16'd37);
    fin_d = 6; fin_d2 = CT ? 15 : 0;
    job(0, 16'd240, 16'd46);
    fin_d2 = 0;

    // Reset mid-WAIT after a requester-0 job left rr at 1.
    fin_d = 0;
    a_1 = 16'd35; b_1 = 16'd15; req_1 = 1'b1;
    grant(1, 16'd35, 16'd15, L);
    repeat (6) tick();
    dc = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr = 0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_gu_ab", {gu_a, gu_b}, 32'd0);
    chk("midrst_res", {res_gcd, res_s | res_t}, 32'd0);
    repeat (MC + 4) tick();
    chk("midrst_no_done", done_cnt - dc, 32'd0);
    fin_d = 12;
    contend(16'd240, 16'd46, 16'd35, 16'd15);

    // Randomized jobs.
    for (int i = 0; i < 10; i++) begin
      int who;
      logic [W-1:0] ra, rb;
      who = int'($urandom_range(0, 1));
      ra = 16'($urandom_range(1, 65535));
      rb = 16'($urandom_range(1, 65535));
      fin_d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, MC));
      stale = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) contend(ra, rb, rb, ra);
      else job(who, ra, rb);
    end
    stale = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, compared=%0d", compared);
    $fatal(1);
  end
endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one extended-Euclid gcd unit between two requesters, e.g. RSA key generation and modular-inverse setup.
- Latches the winner's operands, pulses the unit's start, waits for finish, and returns gcd/s/t with a done pulse to the owner.
- Enforces a cycle timeout; an optional constant-time mode pads every job to a fixed latency to close the gcd timing side channel.

Parameters:
- WIDTH, 8, half operand width; all operands and results are 2*WIDTH bits.
- MAX_CYCLES, 512, WAIT-state cycle budget per job (≥2); also the padded length in constant-time mode.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_0  input  1  requester 0 request; held until gnt_0
- a_0  input  2*WIDTH  requester 0 operand a
- b_0  input  2*WIDTH  requester 0 operand b
- req_1  input  1  requester 1 request
- a_1  input  2*WIDTH  requester 1 operand a
- b_1  input  2*WIDTH  requester 1 operand b
- gnt_0  output  1  one-cycle accept pulse, requester 0
- gnt_1  output  1  one-cycle accept pulse, requester 1
- done_0  output  1  one-cycle result pulse, requester 0
- done_1  output  1  one-cycle result pulse, requester 1
- res_gcd  output  2*WIDTH  result gcd, held until next RESP
- res_s  output  2*WIDTH  Bezout s (two's complement), held
- res_t  output  2*WIDTH  Bezout t (two's complement), held
- res_err  output  1  timeout flag for the last job, held
- busy  output  1  high in any state except IDLE
- gu_start  output  1  gcd unit start pulse
- gu_a  output  2*WIDTH  latched operand a to unit
- gu_b  output  2*WIDTH  latched operand b to unit
- gu_gcd  input  2*WIDTH  unit gcd
- gu_s  input  2*WIDTH  unit s
- gu_t  input  2*WIDTH  unit t
- gu_finish  input  1  unit completion

Behaviour:
- Reset: state IDLE; rr_ptr=0; cnt=0; every output and register 0, including gu_a, gu_b and res_*. Reset mid-job abandons the job with no done pulse. The integration drives the unit's rst_n = ~rst.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: at a clock edge with any req high, pick the winner.
  - Only one req high: that requester wins.
  - Both high: requester rr_ptr wins.
  - On the winning edge: latch its a/b into gu_a/gu_b, record owner, go to LAUNCH.
- LAUNCH (1 cycle): gnt_<owner>=1, gu_start=1, cnt cleared to 0, go to WAIT.
  - Requester must drop req in the cycle after gnt. A req still high in IDLE is a new request.
- WAIT: cnt increments each cycle. gu_finish is sampled only in WAIT, so a stale finish during LAUNCH is ignored.
  - gu_finish=1: capture gu_gcd/s/t into res_*, res_err=0, go to RESP.
  - Otherwise, if cnt==MAX_CYCLES-1: res_* cleared to 0, res_err=1, go to RESP.
  - gu_finish in that same last cycle counts as success.
- RESP (1 cycle): done_<owner>=1; rr_ptr = ~owner; go to IDLE.
- Latency, with gnt in cycle L:
  - Finish seen in cycle F gives done in F+1.
  - Timeout gives done in L+MAX_CYCLES+1.
  - New grant no earlier than done+1.
- Operands reach the unit as-is; zero or equal operands are the unit's concern.
- gu_a/gu_b stay stable from LAUNCH through RESP.
- res_* change only on entering RESP.
- gnt and done never both high in the same cycle. At most one gnt_x and one done_x high per cycle.

Optional Feature:
- Macro GCD_ARB_CONST_TIME_EN.
- Defined:
  - WAIT always lasts exactly MAX_CYCLES cycles. The first gu_finish captures res_* and sets an internal got flag; later finishes are ignored.
  - Exit at cnt==MAX_CYCLES-1; res_err = ~got.
  - done is always at L+MAX_CYCLES+1, independent of operands.
- Undefined: behaviour as above, with early exit on finish.

Test Plan:
- Single job: req_0, a_0=240, b_0=46; unit finishes 20 cycles after start.
  - gnt_0 once; gu_start once.
  - done_0 one cycle after finish; res_gcd=2, res_s=0xFFF7, res_t=0x002F, res_err=0, busy low after.
- Contention: req_0 and req_1 rise on the same edge after reset, (240,46) and (35,15).
  - gnt_0 first, then gnt_1.
  - Second result res_gcd=5, res_s=1, res_t=0xFFFE.
  - Repeat with both requests again: requester 1 now wins first.
- Timeout: gu_finish tied low, MAX_CYCLES=16.
  - done_0 at L+17; res_err=1, res_* all 0; next request is serviced normally.
- Reset mid-WAIT (cnt=5): rst for 1 cycle.
  - No done pulse; all outputs 0; rr_ptr=0; a fresh req_1 is granted in the following IDLE.
- Stale finish: gu_finish high during LAUNCH, low in the first WAIT cycle.
  - Not captured; job waits for the real finish.
- GCD_ARB_CONST_TIME_EN, MAX_CYCLES=64: jobs (240,46) finishing at 20 cycles and (35,15) finishing at 6.
  - Both done at L+65 with correct results; a second gu_finish mid-WAIT is ignored.
